// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared mask encodings, read FSM states and latency counter width
package cpu_mem_pkg;
    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;
    localparam int LAT_W = 4;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rd_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: read-side lane extraction and write-side byte-enable/data shift
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [3:0]  rd_mask,
    input  logic [1:0]  rd_off,
    output logic [31:0] rd_data,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_mask,
    input  logic [1:0]  wr_off,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_word
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    assign byte_sel = 8'(rd_word >> {rd_off, 3'b000});
    assign half_sel = 16'(rd_word >> {rd_off[1], 4'b0000});
    assign rd_data  = rd_mask == MASK_B ? {24'b0, byte_sel} :
                      rd_mask == MASK_H ? {16'b0, half_sel} : rd_word;
    // bytes pushed past lane 3 by a misaligned request simply fall off
    assign wr_be    = wr_mask << wr_off;
    assign wr_word  = wr_data << {wr_off, 3'b000};
endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: word RAM serving CPU fetch/load/store; CPU_MEM_RESP_RANGE_CHECK_EN adds out-of-range errors
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        read_req,
    input  logic [31:0] read_addr,
    output logic [31:0] read_data,
    output logic        read_data_valid,
    input  logic        write_req,
    input  logic [31:0] write_addr,
    input  logic [31:0] write_data,
    input  logic [3:0]  memory_mask,
    output logic        access_error
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    rd_state_t        state;
    logic [LAT_W-1:0] cnt;
    logic [AW-1:0]    rd_idx;
    logic [1:0]       rd_off;
    logic [3:0]       rd_mask;
    logic             rd_oob, req_oob, wr_oob;
    logic [31:0]      rd_aligned, wr_word;
    logic [3:0]       wr_be;
    logic [AW-1:0]    wr_idx;

    assign wr_idx = write_addr[AW+1:2];

`ifdef CPU_MEM_RESP_RANGE_CHECK_EN
    assign req_oob = |read_addr[31:AW+2];
    assign wr_oob  = |write_addr[31:AW+2];
`else
    logic unused_hi;
    assign unused_hi = ^{read_addr[31:AW+2], write_addr[31:AW+2]};
    assign req_oob   = 1'b0;
    assign wr_oob    = 1'b0;
`endif

    mem_lane_align u_align (
        .rd_word(mem[rd_idx]),
        .rd_mask(rd_mask),
        .rd_off (rd_off),
        .rd_data(rd_aligned),
        .wr_data(write_data),
        .wr_mask(memory_mask),
        .wr_off (write_addr[1:0]),
        .wr_be  (wr_be),
        .wr_word(wr_word)
    );

    always_ff @(posedge clk)
        if (write_req && !wr_oob)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_word[8*b +: 8];

    // RESP means "sample and pulse valid at the next edge"; that edge reads pre-write contents
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            read_data       <= '0;
            read_data_valid <= 1'b0;
            access_error    <= 1'b0;
        end else begin
            read_data_valid <= state == S_RESP;
            access_error    <= (state == S_RESP && rd_oob) || (write_req && wr_oob);
            case (state)
                S_IDLE: if (read_req) begin
                    rd_idx  <= read_addr[AW+1:2];
                    rd_off  <= read_addr[1:0];
                    rd_mask <= memory_mask;
                    rd_oob  <= req_oob;
                    cnt     <= LAT_W'(READ_LATENCY - 1);
                    state   <= READ_LATENCY == 1 ? S_RESP : S_WAIT;
                end
                S_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == LAT_W'(1)) state <= S_RESP;
                end
                S_RESP: begin
                    read_data <= rd_oob ? '0 : rd_aligned;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: latency-1 and latency-4 responders on shared stimulus, table + model checks
module tb_cpu_mem_responder;
    import cpu_mem_pkg::*;
    localparam int DEPTH = 1024;
`ifdef CPU_MEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        read_req = 1'b0, write_req = 1'b0;
    logic [31:0] read_addr = '0, write_addr = '0, write_data = '0;
    logic [3:0]  memory_mask = '0;
    logic [31:0] rdata [2];
    logic [1:0]  vld, aerr;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] mem_m [DEPTH];
    logic [31:0] pw_addr, pw_data;
    logic [3:0]  pw_mask;

    typedef struct {
        logic        wen;
        logic [31:0] waddr, wdata;
        logic [3:0]  wmask;
        logic [31:0] raddr;
        logic [3:0]  rmask;
        logic [31:0] exp;
    } vec_t;
    vec_t tbl [10];

    int          resp_at [2];
    logic        pend [2], ev [2], ee [2];
    logic [31:0] pa [2], ed [2];
    logic [3:0]  pm [2];
    logic [31:0] ra, wa, wd;
    logic [3:0]  m;
    logic        rq, wq;
    int          late;

    always #5 clk = ~clk;

    cpu_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .read_data(rdata[0]), .read_data_valid(vld[0]), .write_req(write_req),
        .write_addr(write_addr), .write_data(write_data), .memory_mask(memory_mask),
        .access_error(aerr[0]));

    cpu_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(4)) dut4 (
        .clk(clk), .reset(reset), .read_req(read_req), .read_addr(read_addr),
        .read_data(rdata[1]), .read_data_valid(vld[1]), .write_req(write_req),
        .write_addr(write_addr), .write_data(write_data), .memory_mask(memory_mask),
        .access_error(aerr[1]));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    function automatic logic oob(input logic [31:0] a);
        return RC && (a >= 32'(4 * DEPTH));
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic [3:0] mk);
        logic [31:0] w;
        int o;
        if (oob(a)) return '0;
        w = mem_m[int'((a >> 2) % DEPTH)];
        o = int'(a % 4);
        if (mk == MASK_B) return (w >> (8 * o)) & 32'hFF;
        if (mk == MASK_H) return (w >> (8 * (o & 2))) & 32'hFFFF;
        return w;
    endfunction

    function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
        int w, o;
        w = int'((a >> 2) % DEPTH);
        o = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (mk[i] && i + o < 4) mem_m[w][8*(i+o) +: 8] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] rand_addr(input logic [3:0] mk);
        logic [31:0] base, off;
        base = ($urandom_range(0, 3) == 0) ? 32'(4 * DEPTH) : 32'h0;
        off  = mk == MASK_B ? 32'($urandom_range(0, 3)) : mk == MASK_H ? 32'(2 * $urandom_range(0, 1)) : 32'h0;
        return base + 32'(4 * $urandom_range(0, 15)) + off;
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] mk);
        write_req = 1'b1; write_addr = a; write_data = d; memory_mask = mk;
        if (!oob(a)) m_write(a, d, mk);
        tick;
        write_req = 1'b0;
    endtask

    // single read pulse; optional write (pw_*) placed before edge wr_at
    task automatic do_read(input string name, input logic [31:0] a, input logic [3:0] mk,
                           input logic [31:0] e1, input logic [31:0] e4, input logic er, input int wr_at);
        logic [7:0]  p1 = '0, p4 = '0, q1 = '0, q4 = '0;
        logic [31:0] d1 = '0, d4 = '0;
        read_req = 1'b1; read_addr = a; memory_mask = mk;
        for (int c = 0; c < 8; c++) begin
            if (wr_at != 0 && c == wr_at) begin
                write_req = 1'b1; write_addr = pw_addr; write_data = pw_data; memory_mask = pw_mask;
            end
            tick;
            read_req = 1'b0; write_req = 1'b0;
            p1[c] = vld[0]; p4[c] = vld[1]; q1[c] = aerr[0]; q4[c] = aerr[1];
            if (vld[0]) d1 = rdata[0];
            if (vld[1]) d4 = rdata[1];
        end
        chk({name, " pulse L1"}, 32'(p1), 32'h02);
        chk({name, " pulse L4"}, 32'(p4), 32'h10);
        chk({name, " data L1"}, d1, e1);
        chk({name, " data L4"}, d4, e4);
        chk({name, " err L1"}, 32'(q1), er ? 32'h02 : 32'h0);
        chk({name, " err L4"}, 32'(q4), er ? 32'h10 : 32'h0);
    endtask

    initial begin
        logic [15:0] h1, h4;
        tbl[0] = '{1'b1, 32'h10, 32'hDEADBEEF, MASK_W, 32'h10, MASK_W, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 32'h10, 32'h11223344, MASK_W, 32'h10, MASK_W, 32'h11223344};
        tbl[2] = '{1'b1, 32'h13, 32'h000000AA, MASK_B, 32'h10, MASK_W, 32'hAA223344};
        tbl[3] = '{1'b0, 32'h0,  32'h0,        MASK_B, 32'h13, MASK_B, 32'h000000AA};
        tbl[4] = '{1'b0, 32'h0,  32'h0,        MASK_B, 32'h12, MASK_H, 32'h0000AA22};
        tbl[5] = '{1'b0, 32'h0,  32'h0,        MASK_B, 32'h10, MASK_B, 32'h00000044};
        tbl[6] = '{1'b0, 32'h0,  32'h0,        MASK_B, 32'h10, MASK_H, 32'h00003344};
        tbl[7] = '{1'b1, 32'h12, 32'h0000BEEF, MASK_H, 32'h10, MASK_W, 32'hBEEF3344};
        tbl[8] = '{1'b0, 32'h0,  32'h0,        MASK_B, 32'h11, MASK_B, 32'h00000033};
        tbl[9] = '{1'b1, 32'h20, 32'h12345678, MASK_W, 32'h22, MASK_H, 32'h00001234};

        tick; tick;
        for (int i = 0; i < 2; i++) begin
            chk("reset valid", 32'(vld[i]), 32'h0);
            chk("reset data", rdata[i], 32'h0);
            chk("reset err", 32'(aerr[i]), 32'h0);
        end
        reset = 1'b1;
        tick;

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wen) wr(tbl[i].waddr, tbl[i].wdata, tbl[i].wmask);
            do_read($sformatf("vec%0d", i), tbl[i].raddr, tbl[i].rmask, tbl[i].exp, tbl[i].exp, 1'b0, 0);
        end

        h1 = '0; h4 = '0;
        read_req = 1'b1; read_addr = 32'h10; memory_mask = MASK_W;
        for (int c = 0; c < 13; c++) begin
            if (c == 10) read_req = 1'b0;
            tick;
            h1[c] = vld[0]; h4[c] = vld[1];
        end
        chk("held req pulses L1", 32'(h1), 32'h02AA);
        chk("held req pulses L4", 32'(h4), 32'h0210);

        wr(32'h30, 32'h01020304, MASK_W);
        pw_addr = 32'h30; pw_data = 32'h55; pw_mask = MASK_B;
        do_read("raw edge1", 32'h30, MASK_W, 32'h01020304, 32'h01020355, 1'b0, 1);
        pw_data = 32'h66;
        do_read("raw edge4", 32'h30, MASK_W, 32'h01020355, 32'h01020355, 1'b0, 4);
        do_read("raw after", 32'h30, MASK_W, 32'h01020366, 32'h01020366, 1'b0, 0);

        read_req = 1'b1; read_addr = 32'h10; memory_mask = MASK_W;
        tick;
        read_req = 1'b0;
        tick;
        reset = 1'b0;
        tick;
        chk("rst in wait valid", 32'(vld[1]), 32'h0);
        chk("rst in wait data L4", rdata[1], 32'h0);
        chk("rst in wait data L1", rdata[0], 32'h0);
        chk("rst in wait err", 32'(aerr[1]), 32'h0);
        reset = 1'b1;
        late = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            late += int'(vld[1]);
        end
        chk("no pulse after abort", 32'(late), 32'h0);
        do_read("post reset", 32'h10, MASK_W, 32'hBEEF3344, 32'hBEEF3344, 1'b0, 0);

        wr(32'h0, 32'hCAFEF00D, MASK_W);
        do_read("high addr", 32'(4 * DEPTH), MASK_W, RC ? 32'h0 : 32'hCAFEF00D,
                RC ? 32'h0 : 32'hCAFEF00D, RC, 0);

        reset = 1'b0;
        tick;
        reset = 1'b1;
        for (int w = 0; w < 16; w++) wr(32'(4 * w), $urandom, MASK_W);
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; ed[i] = '0; resp_at[i] = 0;
        end
        for (int e = 0; e < 600; e++) begin
            case ($urandom_range(0, 2))
                0: m = MASK_B;
                1: m = MASK_H;
                default: m = MASK_W;
            endcase
            rq = 1'($urandom_range(0, 1));
            wq = $urandom_range(0, 3) == 0;
            ra = rand_addr(m); wa = rand_addr(m); wd = $urandom;
            read_req = rq; read_addr = ra; write_req = wq; write_addr = wa; write_data = wd; memory_mask = m;
            for (int i = 0; i < 2; i++) begin
                ev[i] = 1'b0;
                ee[i] = wq && oob(wa);
                if (pend[i] && resp_at[i] == e) begin
                    ev[i] = 1'b1;
                    ed[i] = m_read(pa[i], pm[i]);
                    ee[i] = ee[i] | oob(pa[i]);
                    pend[i] = 1'b0;
                end else if (!pend[i] && rq) begin
                    pend[i] = 1'b1;
                    resp_at[i] = e + (i == 0 ? 1 : 4);
                    pa[i] = ra; pm[i] = m;
                end
            end
            if (wq && !oob(wa)) m_write(wa, wd, m);
            tick;
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("rnd%0d valid L%0d", e, i == 0 ? 1 : 4), 32'(vld[i]), 32'(ev[i]));
                chk($sformatf("rnd%0d data L%0d", e, i == 0 ? 1 : 4), rdata[i], ed[i]);
                chk($sformatf("rnd%0d err L%0d", e, i == 0 ? 1 : 4), 32'(aerr[i]), 32'(ee[i]));
            end
        end
        read_req = 1'b0; write_req = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the simple CPU's load/store/fetch interface. It owns a word-organised RAM, accepts one outstanding read at a time with a configurable fixed latency, performs single-cycle byte-masked writes, and returns byte/halfword read data right-aligned as the CPU's load path expects. It sits directly on the CPU's `read_*`/`write_*`/`memory_mask` ports and serves both instruction fetch and data access.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two.
- `READ_LATENCY`, 1: edges from read accept to `read_data_valid`; legal range 1..15.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-low; clock and reset ports are named `clk` and `reset` as elsewhere in the CPU.
- `read_req` in 1: read request; may be held or re-pulsed by the CPU while waiting.
- `read_addr` in 32: byte address of read.
- `read_data` out 32: read result, right-aligned per mask.
- `read_data_valid` out 1: one-cycle pulse, `read_data` valid.
- `write_req` in 1: write strobe, one cycle per write.
- `write_addr` in 32: byte address of write.
- `write_data` in 32: write data, right-aligned (low byte/halfword used for SB/SH).
- `memory_mask` in 4: 0001 byte, 0011 halfword, 1111 word; applies to the request present that cycle.
- `access_error` out 1: one-cycle pulse on out-of-range access (only with range check enabled).

## Operation
- Read FSM: IDLE, WAIT, RESP.
  - IDLE: `read_req`=1 at an edge -> latch `read_addr`, `memory_mask`; load latency counter with READ_LATENCY-1; go WAIT (or RESP directly if READ_LATENCY=1).
  - WAIT: counter decrements each edge; `read_req` ignored; at 0 go RESP.
  - RESP: on entry edge RAM word sampled, lane-shifted, registered to `read_data`; `read_data_valid`=1 for this one cycle; `read_req` ignored; next edge -> IDLE.
- Lane alignment: word index = addr[log2(DEPTH)+1:2]; byte offset = addr[1:0]. Byte: `read_data`={24'b0, byte[offset]}; halfword: {16'b0, half[addr[1]]}; word: full word. Sign extension is the CPU's job.
- Writes: independent of read FSM, accepted in any state. `write_req`=1 at edge -> byte enables = `memory_mask` << addr[1:0]; bytes of `write_data` shifted left by 8*addr[1:0]; only enabled bytes updated. Misaligned halfword/word never occur (CPU traps them); if presented, bits shifted beyond byte 3 are dropped.
- Read/write same word at the RESP sampling edge: read returns pre-write contents. Writes at any earlier edge are visible.
- `read_data` holds its last value between pulses.

## Timing
- Request sampled at edge k in IDLE -> `read_data_valid` high from edge k+READ_LATENCY for exactly one cycle; next accept earliest at edge k+READ_LATENCY+1.
- Write takes effect at the sampling edge; zero-latency, no acknowledge.
- Reset (low at an edge): FSM -> IDLE, `read_data`=0, `read_data_valid`=0, `access_error`=0, counter=0. RAM contents not reset. Reset during WAIT/RESP aborts the read; no valid pulse follows.
- No combinational path from any input to any output.

## Configuration
- `CPU_MEM_RESP_RANGE_CHECK_EN` defined: address >= 4*DEPTH is out of range. Read: `read_data`=0 with normal valid pulse, plus `access_error` pulse same cycle. Write: dropped, `access_error` pulse the cycle after the write edge.
- Undefined: upper address bits ignored, address wraps modulo 4*DEPTH; `access_error` tied 0.

## Structure
- Package `cpu_mem_pkg`: mask constants (MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111), read FSM state enum, latency counter width constant.
- One sub-module `mem_lane_align`: combinational read-side extraction and write-side byte-enable/data shift from mask and addr[1:0]; used by both paths.

## Test plan
- Word write 0xDEADBEEF @0x10, then read @0x10 mask 1111, READ_LATENCY=1 -> valid one cycle after accept, `read_data`=0xDEADBEEF.
- SB 0x000000AA @0x13 over 0x11223344 -> word 0xAA223344; LB @0x13 -> 0x000000AA; LH @0x12 -> 0x0000AA22.
- READ_LATENCY=4, `read_req` held high 10 cycles -> exactly one valid pulse 4 edges after accept, second accept at edge 5, second pulse at edge 9.
- Write 0x55 byte to word being read at its RESP edge -> returned data is old value; subsequent read shows new value.
- Reset low during WAIT -> no valid pulse, outputs 0; next read after reset completes normally.
- With range check, read @4*DEPTH -> `read_data`=0, `access_error` and valid pulse together; without it, same address returns word 0.
